firebird7_in_gate1_tessent_data_mux_sync: RTL

Parametrised, registered N-source data mux for the firebird7_in gate1 IJTAG network: selects one of NUM_SRC WIDTH-bit sources (source 0 is functional data, sources 1..NUM_SRC-1 are IJTAG-driven) onto a registered output. Source changes use a valid/ready request and a break-before-make guard interval, during which the output is forced to a safe value. This prevents a functional/test source switch from glitching downstream logic. It sits between the instrument SIB/TDR outputs and the functional datapath, replacing the combinational 2:1 data mux where switch-over must be clean.

---
 rtl/firebird7_in_gate1_data_mux_pkg.sv | 8 +
 rtl/firebird7_in_gate1_guard_counter.sv | 18 +
 rtl/firebird7_in_gate1_tessent_data_mux_sync.sv | 78 +++++++
 3 files changed

// File: rtl/firebird7_in_gate1_data_mux_pkg.sv
// firebird7_in_gate1_data_mux_pkg: shared state type, select-width helper and default safe value for the IJTAG data mux.
package firebird7_in_gate1_data_mux_pkg;
  typedef enum logic {ST_ACTIVE, ST_GUARD} state_t;
  localparam logic [63:0] DEF_SAFE_VALUE = '0;
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/firebird7_in_gate1_guard_counter.sv
// firebird7_in_gate1_guard_counter: loadable down-counter with zero flag timing the break-before-make interval.
module firebird7_in_gate1_guard_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_count;
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_dec && r_count != '0) r_count <= r_count - 1'b1;
  assign o_zero = r_count == '0;
endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// firebird7_in_gate1_tessent_data_mux_sync: registered N-source mux with guarded source switch-over.
// Optional readback of source 0 via FIREBIRD7_IN_DATA_MUX_CAPTURE_EN.
module firebird7_in_gate1_tessent_data_mux_sync
  import firebird7_in_gate1_data_mux_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int NUM_SRC = 2,
  parameter int GUARD = 2,
  parameter logic [WIDTH-1:0] SAFE_VALUE = DEF_SAFE_VALUE[WIDTH-1:0],
  localparam int SELW = sel_w(NUM_SRC)
) (
  input  logic                     ijtag_tck,
  input  logic                     ijtag_reset,
  input  logic                     sel_req_valid,
  input  logic [SELW-1:0]          sel_req_src,
  output logic                     sel_req_ready,
  input  logic [NUM_SRC*WIDTH-1:0] src_data_in,
`ifdef FIREBIRD7_IN_DATA_MUX_CAPTURE_EN
  input  logic                     capture_en,
  output logic [WIDTH-1:0]         capture_data,
`endif
  output logic [WIDTH-1:0]         data_out,
  output logic [SELW-1:0]          active_src,
  output logic                     switching,
  output logic                     sel_err
);
  localparam int CW = $clog2(GUARD + 1);
  state_t r_state, w_state_n;
  logic [SELW-1:0] r_active, r_pending, w_active_n;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_src [NUM_SRC];
  logic r_err, w_accept, w_oor, w_switch, w_zero;
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign w_src[k] = src_data_in[k*WIDTH +: WIDTH];
  end
  assign sel_req_ready = r_state == ST_ACTIVE;
  assign w_accept = sel_req_valid & sel_req_ready;
  assign w_oor = int'(sel_req_src) >= NUM_SRC;
  assign w_switch = w_accept & ~w_oor & (sel_req_src != r_active);
  always_comb begin
    w_state_n = (r_state == ST_ACTIVE) ? (w_switch ? ST_GUARD : ST_ACTIVE) : (w_zero ? ST_ACTIVE : ST_GUARD);
    w_active_n = (r_state == ST_GUARD && w_zero) ? r_pending : r_active;
  end
  // Output looks ahead to the next state so the new source appears on the edge that leaves GUARD.
  always_ff @(posedge ijtag_tck)
    if (!ijtag_reset) begin
      r_state <= ST_ACTIVE;
      r_active <= '0;
      r_pending <= '0;
      r_data <= SAFE_VALUE;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_active <= w_active_n;
      if (w_switch) r_pending <= sel_req_src;
      r_data <= (w_state_n == ST_GUARD) ? SAFE_VALUE : w_src[w_active_n];
      if (w_accept && w_oor) r_err <= 1'b1;
    end
  firebird7_in_gate1_guard_counter #(.W(CW)) u_guard (
    .i_clk(ijtag_tck),
    .i_rst_n(ijtag_reset),
    .i_load(w_switch),
    .i_load_val(CW'(GUARD - 1)),
    .i_dec(r_state == ST_GUARD),
    .o_zero(w_zero)
  );
`ifdef FIREBIRD7_IN_DATA_MUX_CAPTURE_EN
  logic [WIDTH-1:0] r_capture;
  always_ff @(posedge ijtag_tck)
    if (!ijtag_reset) r_capture <= SAFE_VALUE;
    else if (capture_en) r_capture <= w_src[0];
  assign capture_data = r_capture;
`endif
  assign data_out = r_data;
  assign active_src = r_active;
  assign switching = r_state == ST_GUARD;
  assign sel_err = r_err;
endmodule
